// File: rtl/layer_transfer.sv
// Copies word_count 256-bit words from a source-layer BRAM to a destination layer, one word per cycle.
// A word's write lands two cycles after its read address. There is no backpressure; abort cancels the transfer.
module layer_transfer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              abort,
  input  logic [DATA_W-1:0] src_data,
  output logic [ADDR_W-1:0] trans_addr1,
  output logic [ADDR_W-1:0] trans_addr2,
  output logic              write,
  output logic [ADDR_W-1:0] reg_trans_addr1,
  output logic [ADDR_W-1:0] reg_trans_addr2,
  output logic              reg_write,
  output logic [DATA_W-1:0] layer_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wc;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_rd_vld;
  logic                r_write;
  logic                r_p1_vld;
  logic [ADDR_W-1:0]   r_p1_addr;
  logic                r_reg_write;
  logic [ADDR_W-1:0]   r_dst_addr;
  logic [DATA_W-1:0]   r_layer_data;
  logic                r_busy;
  logic                r_done;

  logic                w_kill;
  logic                w_last;
  logic                w_p1_take;

  // abort only matters while words are in flight; in IDLE/FIN it is ignored
  assign w_kill    = abort && ((r_state == READ) || (r_state == DRAIN));
  assign w_last    = (r_rd_addr == (r_wc - ONE));
  assign w_p1_take = r_p1_vld && !w_kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_wc         <= '0;
      r_rd_addr    <= '0;
      r_rd_vld     <= 1'b0;
      r_write      <= 1'b0;
      r_p1_vld     <= 1'b0;
      r_p1_addr    <= '0;
      r_reg_write  <= 1'b0;
      r_dst_addr   <= '0;
      r_layer_data <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // stage 1 lines up with src_data, stage 2 with layer_data
      r_p1_vld    <= r_rd_vld && !w_kill;
      r_reg_write <= w_p1_take;
      if (r_rd_vld) begin
        r_p1_addr <= r_rd_addr;
      end
      if (w_p1_take) begin
        r_dst_addr   <= r_p1_addr;
        r_layer_data <= src_data;
      end
      r_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (word_count != '0) begin
              r_wc      <= word_count;
              r_rd_addr <= '0;
              r_rd_vld  <= 1'b1;
              r_write   <= 1'b1;
              r_state   <= READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        READ: begin
          if (w_kill) begin
            r_rd_vld <= 1'b0;
            r_write  <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= FIN;
          end else if (w_last) begin
            r_rd_vld <= 1'b0;
            r_state  <= DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + ONE;
          end
        end
        DRAIN: begin
          if (w_kill || (!r_p1_vld && !r_reg_write)) begin
            r_write <= 1'b0;
            r_done  <= 1'b1;
            r_state <= FIN;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign trans_addr1     = r_rd_addr;
  assign trans_addr2     = r_rd_addr;
  assign write           = r_write;
  assign reg_trans_addr1 = r_dst_addr;
  assign reg_trans_addr2 = r_dst_addr;
  assign reg_write       = r_reg_write;
  assign layer_data      = r_layer_data;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_layer_transfer.sv
// Bench for layer_transfer: a BRAM model feeds src_data and a scoreboard checks every destination write.
module tb_layer_transfer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [9:0]   word_count;
  logic         abort;
  logic [255:0] src_data;
  logic [9:0]   trans_addr1, trans_addr2, reg_trans_addr1, reg_trans_addr2;
  logic         write, reg_write, busy, done;
  logic [255:0] layer_data;

  layer_transfer #(.ADDR_W(10), .DATA_W(256)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count), .abort(abort),
    .src_data(src_data), .trans_addr1(trans_addr1), .trans_addr2(trans_addr2),
    .write(write), .reg_trans_addr1(reg_trans_addr1), .reg_trans_addr2(reg_trans_addr2),
    .reg_write(reg_write), .layer_data(layer_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]   a;
    logic [255:0] d;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int rw_cnt, wr_cnt, done_cnt, first_rw, last_rw, done_cyc, last_addr;

  function automatic logic [255:0] fdat(input logic [9:0] a1, input logic [9:0] a2);
    logic [31:0] lo, hi;
    lo = 32'h0BAD0000 ^ (32'(a1) * 32'd7);
    hi = 32'hC0DE0000 + 32'(a2);
    return {{4{hi}}, {4{lo}}};
  endfunction

  // source BRAM: lower half addressed by trans_addr1, upper by trans_addr2, 1-cycle latency
  always @(posedge clk) src_data <= fdat(trans_addr1, trans_addr2);
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (reg_write) begin
        rw_cnt++;
        if (first_rw < 0) first_rw = cyc - t0 + 1;
        last_rw = cyc - t0 + 1;
        last_addr = reg_trans_addr1;
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: reg_write at addr %0d, none expected", reg_trans_addr1);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (reg_trans_addr1 !== e.a || reg_trans_addr2 !== e.a || layer_data !== e.d) begin
            bad++;
            $display("FAIL sb_word: got a1=%0d a2=%0d d=%h, expected a=%0d d=%h",
                     reg_trans_addr1, reg_trans_addr2, layer_data, e.a, e.d);
          end
        end
      end
      if (write) wr_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0 + 1;
      end
    end
  end

  task automatic clr_mon();
    rw_cnt = 0; wr_cnt = 0; done_cnt = 0;
    first_rw = -1; last_rw = -1; done_cyc = -1; last_addr = -1;
  endtask

  // accepting edge is cycle 0; cycle 1 is the first cycle after it
  task automatic start_xfer(input int n, input logic ab);
    @(posedge clk); #1;
    clr_mon();
    word_count = 10'(n);
    start = 1'b1;
    abort = ab;
    for (int i = 0; i < n; i++) q.push_back('{a: 10'(i), d: fdat(10'(i), 10'(i))});
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    t0 = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; word_count = '0;
    #3;
    total++;
    if ({trans_addr1, trans_addr2, write, reg_trans_addr1, reg_trans_addr2, reg_write,
         layer_data, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: outputs not all zero (busy=%b write=%b rw=%b a=%0d)",
               busy, write, reg_write, trans_addr1);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    start_xfer(4, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      total++;
      if (busy !== (i <= 8)) begin
        bad++;
        $display("FAIL basic_busy: cycle %0d busy=%b expected %b", i, busy, (i <= 8));
      end
    end
    total++;
    if (rw_cnt != 4 || first_rw != 3 || last_rw != 6) begin
      bad++;
      $display("FAIL basic_rw: count=%0d first=%0d last=%0d expected 4/3/6", rw_cnt, first_rw, last_rw);
    end
    total++;
    if (done_cnt != 1 || done_cyc != 8) begin
      bad++;
      $display("FAIL basic_done: count=%0d cycle=%0d expected 1/8", done_cnt, done_cyc);
    end
    total++;
    if (trans_addr1 !== 10'd3 || reg_trans_addr1 !== 10'd3 || write !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: src=%0d dst=%0d write=%b expected 3/3/0", trans_addr1, reg_trans_addr1, write);
    end
  endtask

  task automatic test_zero();
    start_xfer(0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total++;
      if (done !== (i == 1) || busy !== (i == 1)) begin
        bad++;
        $display("FAIL zero_pulse: cycle %0d done=%b busy=%b expected %b", i, done, busy, (i == 1));
      end
    end
    total++;
    if (wr_cnt != 0 || rw_cnt != 0) begin
      bad++;
      $display("FAIL zero_strobes: write=%0d reg_write=%0d expected 0/0", wr_cnt, rw_cnt);
    end
  endtask

  task automatic test_full();
    start_xfer(1023, 1'b0);
    for (int i = 1; i <= 1100 && done_cnt == 0; i++) @(negedge clk);
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL full_timeout: no done within 1100 cycles, got %0d expected 1", done_cnt);
    end
    total++;
    if (rw_cnt != 1023 || last_addr != 1022 || done_cyc != 1027) begin
      bad++;
      $display("FAIL full_count: count=%0d last=%0d done=%0d expected 1023/1022/1027",
               rw_cnt, last_addr, done_cyc);
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL full_queue: %0d words left, expected 0", q.size());
    end
    q.delete();
  endtask

  task automatic test_abort();
    start_xfer(10, 1'b0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || write !== 1'b0 || reg_write !== 1'b0) begin
      bad++;
      $display("FAIL abort_next: done=%b write=%b reg_write=%b expected 1/0/0", done, write, reg_write);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: busy=%b done=%b expected 0/0", busy, done);
    end
    repeat (6) @(negedge clk);
    total++;
    if (rw_cnt > 3 || rw_cnt < 1 || done_cnt != 1 || wr_cnt != 4) begin
      bad++;
      $display("FAIL abort_count: rw=%0d done=%0d write=%0d expected rw 1..3, done 1, write 4",
               rw_cnt, done_cnt, wr_cnt);
    end
    q.delete();
  endtask

  task automatic test_reset_mid();
    start_xfer(10, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({trans_addr1, trans_addr2, write, reg_trans_addr1, reg_trans_addr2, reg_write,
         layer_data, busy, done} !== '0) begin
      bad++;
      $display("FAIL rstmid_outputs: not zero (busy=%b write=%b rw=%b a=%0d)", busy, write, reg_write, trans_addr1);
    end
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clr_mon();
    repeat (6) @(negedge clk);
    total++;
    if (rw_cnt != 0 || wr_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet: rw=%0d write=%0d busy=%b expected 0/0/0", rw_cnt, wr_cnt, busy);
    end
    start_xfer(2, 1'b0);
    repeat (8) @(negedge clk);
    total++;
    if (rw_cnt != 2 || first_rw != 3 || last_rw != 4 || done_cnt != 1 || done_cyc != 6) begin
      bad++;
      $display("FAIL rstmid_restart: rw=%0d first=%0d last=%0d done=%0d@%0d expected 2/3/4/1@6",
               rw_cnt, first_rw, last_rw, done_cnt, done_cyc);
    end
  endtask

  task automatic test_busy_start();
    // abort raised with start in IDLE: start must win
    start_xfer(6, 1'b1);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = 10'd3;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(negedge clk);
    total++;
    if (rw_cnt != 6 || done_cnt != 1 || done_cyc != 10) begin
      bad++;
      $display("FAIL busy_start: rw=%0d done=%0d@%0d expected 6/1@10", rw_cnt, done_cnt, done_cyc);
    end
    total++;
    if (q.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_queue: left=%0d busy=%b expected 0/0", q.size(), busy);
    end
    q.delete();
  endtask

  initial begin
    clr_mon();
    test_reset();
    test_basic();
    test_zero();
    test_abort();
    test_reset_mid();
    test_busy_start();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_transfer.md
LAYER_TRANSFER -- requirements
Module: layer_transfer

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_W, 10, BRAM address width
- DATA_W, 256, transfer word width (two 128-bit halves)
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock for all logic
- rst, in, 1, asynchronous active-low reset
- start, in, 1, request to begin a transfer; sampled only in IDLE
- word_count, in, ADDR_W, number of words to move; sampled with start
- abort, in, 1, synchronous cancel
- src_data, in, DATA_W, source-layer BRAM2 read data {upper, lower}; 1-cycle read latency
- trans_addr1, out, ADDR_W, source read address, lower half
- trans_addr2, out, ADDR_W, source read address, upper half
- write, out, 1, source-side transfer strobe (forces the source address mux)
- reg_trans_addr1, out, ADDR_W, destination write address, lower half
- reg_trans_addr2, out, ADDR_W, destination write address, upper half
- reg_write, out, 1, destination write enable (one word per cycle)
- layer_data, out, DATA_W, registered word feeding the destination layer input
- busy, out, 1, high from accepted start until the done cycle inclusive
- done, out, 1, one-cycle completion or abort pulse

Function
REQ-003 The FSM SHALL have the states IDLE, READ, DRAIN and FIN.
REQ-004 IDLE: start=1 with word_count>0 SHALL latch word_count, clear the read counter, and go to READ on the next edge.
REQ-005 IDLE: start=1 with word_count=0 SHALL go directly to FIN, producing no reg_write.
REQ-006 READ: each cycle, trans_addr1 = trans_addr2 = read counter k, starting at 0; write=1; k increments by 1.
REQ-007 READ SHALL go to DRAIN in the cycle after k = word_count-1 has been presented.
REQ-008 Word k SHALL appear on src_data one cycle after its address and SHALL be registered into layer_data on that edge.
REQ-009 Word k SHALL be written to the destination two cycles after its address: layer_data = word k, reg_trans_addr1 = reg_trans_addr2 = k, reg_write=1, all in the same cycle.
REQ-010 Address and valid SHALL travel through a 2-stage pipeline so that reg_trans_addr* and reg_write stay aligned with layer_data.
REQ-011 DRAIN SHALL hold write=1 and last trans_addr* value until the pipeline is empty (last reg_write issued), then go to FIN.
REQ-012 FIN SHALL assert done=1 for exactly one cycle, keep busy=1, and return to IDLE.
REQ-013 reg_write SHALL be high for exactly word_count cycles per transfer, contiguous, with destination addresses 0..word_count-1 in order.
REQ-014 start while not in IDLE SHALL be ignored; word_count changes after acceptance SHALL have no effect.
REQ-015 abort in READ or DRAIN SHALL, on the next edge:
- clear pipeline valids (no further reg_write)
- deassert write
- go to FIN
REQ-016 abort in IDLE or FIN SHALL have no effect; abort together with start in IDLE: start wins.
REQ-017 Counters SHALL be ADDR_W bits; word_count=2^ADDR_W-1 SHALL complete without wrap. The final address SHALL be 1022 for ADDR_W=10.
REQ-018 Outside READ/DRAIN, write=0 and reg_write=0; trans_addr* and reg_trans_addr* SHALL hold their last values.

Reset
REQ-019 rst=0 SHALL immediately force, regardless of clk:
- state IDLE
- write, reg_write, busy, done = 0
- all addresses, counters, pipeline valids and layer_data = 0
REQ-020 Reset mid-transfer SHALL discard the transfer; no reg_write SHALL occur after reset release until a new start.

Verification
REQ-021 Scenario basic: start, word_count=4, src_data = f(addr) -> reg_write on cycles 3..6 after start, addresses 0..3, layer_data = f(0)..f(3), done at cycle 8, busy cycles 1..8.
REQ-022 Scenario zero: start with word_count=0 -> done one cycle later, reg_write and write never asserted.
REQ-023 Scenario full: word_count=1023 -> exactly 1023 reg_write pulses, last address 1022, no wrap to 0.
REQ-024 Scenario abort: word_count=10, abort in 4th READ cycle -> reg_write count at most 3, done pulse next cycle, IDLE after.
REQ-025 Scenario reset mid-transfer: rst low during READ -> all outputs 0 within the same cycle; after release, no activity until start; a new start with word_count=2 behaves as in REQ-021.
REQ-026 Scenario busy start: second start during READ -> ignored, a single done, word count unchanged.
